// File: rtl/red_seq_pkg.sv
// Shared types and constants for the RED reduction sequencer.
// Optional op counter enabled with RED_SEQ_OPCNT_EN.
package red_seq_pkg;

    localparam int ACC_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_C = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_D = 2'd2;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice; g is the carry out of the slice
// (including cin), p is the group propagate.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       g,
    output logic       p
);

    logic [3:0] gi;
    logic [3:0] pi;
    logic [3:0] c;

    assign gi = a & b;
    assign pi = a ^ b;

    assign c[0] = cin;
    assign c[1] = gi[0] | (pi[0] & cin);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & cin);

    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0])
             | (pi[3] & pi[2] & pi[1] & pi[0] & cin);
    assign p = &pi;
    assign s = pi ^ c;

endmodule

// File: rtl/red_seq_ctrl.sv
// Nibble-serial RED engine: Sum = sext16(a+b+c+d) using one cla_4bit.
// Define RED_SEQ_OPCNT_EN to add the saturating op_count output.
module red_seq_ctrl
    import red_seq_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Sum,
`ifdef RED_SEQ_OPCNT_EN
    output logic [15:0] op_count,
`endif
    output logic        busy
);

    localparam int NIB_CNT = ACC_W / 4;
    localparam int NIB_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

    state_t state;
    state_t state_nxt;

    logic [NIB_CNT-1:0][3:0] acc;
    logic [NIB_CNT-1:0][3:0] acc_upd;
    logic [NIB_CNT-1:0][3:0] addend;

    logic [7:0]       byte_b;
    logic [7:0]       byte_c;
    logic [7:0]       byte_d;
    logic [7:0]       byte_sel;
    logic [1:0]       op_idx;
    logic [NIB_W-1:0] nib_idx;
    logic             carry;
    logic [3:0]       cla_s;
    logic             cla_g;
    logic             cla_p_unused;
    logic             last_nib;
    logic             last_op;

    assign last_nib  = (nib_idx == NIB_W'(NIB_CNT - 1));
    assign last_op   = (op_idx == OP_D);
    assign in_ready  = (state == IDLE);
    assign busy      = (state == ADD);
    assign out_valid = (state == DONE);

    always_comb begin
        byte_sel = byte_c;
        case (op_idx)
            OP_B:    byte_sel = byte_b;
            OP_D:    byte_sel = byte_d;
            default: byte_sel = byte_c;
        endcase
        addend = {{(ACC_W-8){byte_sel[7]}}, byte_sel};
    end

    cla_4bit u_cla (
        .a   (acc[nib_idx]),
        .b   (addend[nib_idx]),
        .cin (carry),
        .s   (cla_s),
        .g   (cla_g),
        .p   (cla_p_unused)
    );

    always_comb begin
        acc_upd          = acc;
        acc_upd[nib_idx] = cla_s;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = ADD;
            ADD:  if (last_nib && last_op) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            carry   <= 1'b0;
            op_idx  <= '0;
            nib_idx <= '0;
            byte_b  <= '0;
            byte_c  <= '0;
            byte_d  <= '0;
            Sum     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc     <= {{(ACC_W-8){A[15]}}, A[15:8]};
                        byte_b  <= A[7:0];
                        byte_c  <= B[15:8];
                        byte_d  <= B[7:0];
                        carry   <= 1'b0;
                        op_idx  <= '0;
                        nib_idx <= '0;
                    end
                end
                ADD: begin
                    acc <= acc_upd;
                    // MSB-nibble carry out is dropped; the range fits ACC_W
                    if (last_nib) begin
                        carry   <= 1'b0;
                        nib_idx <= '0;
                        op_idx  <= last_op ? 2'd0 : op_idx + 2'd1;
                        if (last_op)
                            Sum <= {{(16-ACC_W){acc_upd[NIB_CNT-1][3]}},
                                    acc_upd};
                    end else begin
                        carry   <= cla_g;
                        nib_idx <= nib_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RED_SEQ_OPCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            op_count <= '0;
        else if (out_valid && out_ready && op_count != 16'hFFFF)
            op_count <= op_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Self-checking bench for red_seq_ctrl against a signed-sum model.
// Build with RED_SEQ_OPCNT_EN to also check op_count.
module tb_red_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        busy;
`ifdef RED_SEQ_OPCNT_EN
    logic [15:0] op_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    red_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
`ifdef RED_SEQ_OPCNT_EN
        .op_count  (op_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_sum(input logic [15:0] a,
                                            input logic [15:0] b);
        int s;
        s = int'($signed(a[15:8])) + int'($signed(a[7:0]))
          + int'($signed(b[15:8])) + int'($signed(b[7:0]));
        return s[15:0];
    endfunction

    task automatic check_cnt(input string name);
`ifdef RED_SEQ_OPCNT_EN
        checks++;
        if (op_count !== exp_cnt[15:0]) begin
            errors++;
            $display("FAIL %s op_count: got %0d want %0d",
                     name, op_count, exp_cnt);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // One full transaction; hold = cycles of out_ready low in DONE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input bit toggle, input int hold,
                         input string name);
        logic [15:0] exp;
        int cyc;
        int bcnt;
        bit bad;
        exp = ref_sum(a, b);
        A = a;
        B = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s in_ready: got 0 want 1", name);
        end
        tick();
        in_valid = 1'b0;
        cyc = 0;
        bcnt = 0;
        while (!out_valid && cyc < 40) begin
            if (busy) bcnt++;
            if (toggle) begin
                A = 16'($urandom);
                B = 16'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL %s latency: got %0d want 9", name, cyc);
        end
        checks++;
        if (bcnt !== 9 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %0d cycles want 9", name, bcnt);
        end
        checks++;
        if (Sum !== exp) begin
            errors++;
            $display("FAIL %s Sum: got %h want %h", name, Sum, exp);
        end
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            A = 16'($urandom);
            if (Sum !== exp || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad = 1'b1;
            tick();
        end
        if (hold > 0) begin
            checks++;
            if (bad || Sum !== exp) begin
                errors++;
                $display("FAIL %s hold: Sum %h want %h ov %b ir %b",
                         name, Sum, exp, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: ov %b want 0, ir %b want 1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        A = 16'h1234;
        B = 16'h5678;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0
            || Sum !== 16'h0000) begin
            errors++;
            $display("FAIL reset: ir %b ov %b busy %b Sum %h want 1 0 0 0000",
                     in_ready, out_valid, busy, Sum);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        exp_cnt = 0;
        check_cnt("reset");
    endtask

    task automatic test_basic();
        do_op(16'h0102, 16'h0304, 1'b0, 0, "basic");
        checks++;
        if (Sum !== 16'h000A) begin
            errors++;
            $display("FAIL basic_const: got %h want 000a", Sum);
        end
    endtask

    task automatic test_extremes();
        do_op(16'h8080, 16'h8080, 1'b0, 0, "neg_ext");
        checks++;
        if (Sum !== 16'hFE00) begin
            errors++;
            $display("FAIL neg_const: got %h want fe00", Sum);
        end
        do_op(16'h7F7F, 16'h7F7F, 1'b0, 0, "pos_ext");
        checks++;
        if (Sum !== 16'h01FC) begin
            errors++;
            $display("FAIL pos_const: got %h want 01fc", Sum);
        end
    endtask

    task automatic test_mixed_toggle();
        do_op(16'hFF01, 16'h0280, 1'b1, 0, "mixed");
        checks++;
        if (Sum !== 16'hFF82) begin
            errors++;
            $display("FAIL mixed_const: got %h want ff82", Sum);
        end
    endtask

    task automatic test_backpressure();
        do_op(16'h05F0, 16'hC033, 1'b0, 20, "backpressure");
        check_cnt("backpressure");
    endtask

    task automatic test_reset_mid();
        A = 16'h7F7F;
        B = 16'h7F7F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_cnt = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0
            || Sum !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: ov %b ir %b busy %b Sum %h",
                     out_valid, in_ready, busy, Sum);
        end
        check_cnt("reset_mid");
        do_op(16'h0101, 16'h0101, 1'b0, 0, "after_reset");
        checks++;
        if (Sum !== 16'h0004) begin
            errors++;
            $display("FAIL after_reset_const: got %h want 0004", Sum);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            do_op(16'($urandom), 16'($urandom), 1'b1,
                  int'($urandom_range(0, 3)), "random");
        check_cnt("random");
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        int t_acc[$];
        int n_acc;
        int n_done;
        int cyc;
        logic [15:0] exp;
        n_acc = 0;
        n_done = 0;
        A = 16'($urandom);
        B = 16'($urandom);
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (n_done < 5 && cyc < 120) begin
            if (in_valid && in_ready) begin
                q.push_back(ref_sum(A, B));
                t_acc.push_back(cyc);
                n_acc++;
            end
            if (out_valid && out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                checks++;
                if (Sum !== exp) begin
                    errors++;
                    $display("FAIL b2b Sum: got %h want %h", Sum, exp);
                end
                n_done++;
                exp_cnt++;
            end
            tick();
            cyc++;
            A = 16'($urandom);
            B = 16'($urandom);
            if (n_acc >= 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (n_done !== 5) begin
            errors++;
            $display("FAIL b2b done: got %0d want 5", n_done);
        end
        for (int i = 1; i < t_acc.size(); i++) begin
            checks++;
            if (t_acc[i] - t_acc[i-1] !== 11) begin
                errors++;
                $display("FAIL b2b spacing: got %0d want 11",
                         t_acc[i] - t_acc[i-1]);
            end
        end
        tick();
        check_cnt("b2b");
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_mixed_toggle();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/red_seq_ctrl.md
Name: red_seq_ctrl

Overview:
- Multi-cycle sequencer for the RED (reduction) operation. It time-shares one 4-bit carry-lookahead slice (cla_4bit) across nibbles and operands instead of using a full adder tree.
- It sits beside the ALU as a low-area RED engine.
- Valid/ready handshake on input and output; one operation in flight.
- Result is the sign-extended sum of the four signed bytes of A and B.

Parameters:
- ACC_W, 12, accumulator width; holds the worst-case 4-byte signed sum with margin; must be a multiple of 4.
- NIB_CNT, ACC_W/4, nibble cycles per operand addition (derived; not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A/B are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  16  operand {a,b}: a=A[15:8], b=A[7:0], signed bytes.
- B  input  16  operand {c,d}: c=B[15:8], d=B[7:0], signed bytes.
- out_valid  output  1  Sum is valid.
- out_ready  input  1  consumer accepts Sum.
- Sum  output  16  sext16(a+b+c+d).
- busy  output  1  high in ADD state.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); no other clock or reset domains.
- States: IDLE, ADD, DONE. Encoding localparam; any illegal state returns to IDLE next edge.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; busy=0; Sum=16'h0000.
  - acc, carry, op_idx, nib_idx = 0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready edge: latch A and B; acc <= sext12(a); op_idx=0; nib_idx=0; carry=0; go to ADD.
- ADD (busy=1, in_ready=0):
  - Addend order: op_idx 0=c, 1=b, 2=d; each is sext12 of its byte.
  - Each cycle, cla_4bit computes acc[nib] + addend[nib] + carry. Result nibble is written into acc[nib]; G is registered as carry.
  - nib_idx 0..NIB_CNT-1. At the last nibble, carry is cleared, nib_idx wraps to 0, and op_idx increments.
  - After op_idx=2 and its last nibble, go to DONE.
  - ADD lasts exactly 3*NIB_CNT = 9 cycles; the carry out of the MSB nibble is discarded.
- DONE:
  - out_valid=1; Sum = {4{acc[11]}, acc}. Sum is registered and stable while out_valid=1.
  - On out_valid&out_ready edge: out_valid <= 0, go to IDLE.
  - No input accept in the same cycle; the next accept is earliest one cycle later.
- Latency:
  - Accept edge T → out_valid high after edge T+9.
  - Minimum issue interval is 11 cycles when out_ready is held high.
- Arithmetic:
  - Exact two's-complement sum over range [-512, +508]; never overflows ACC_W.
  - No saturation, no flags.
- Boundary conditions:
  - in_valid held in ADD/DONE is ignored; the operands are not re-sampled.
  - A/B changing after accept has no effect.
  - out_ready low holds DONE indefinitely with Sum stable.
  - rst asserted in any state: next edge gives reset values. A partial result is discarded; out_valid drops even if a result was pending.
  - rst and in_valid together: rst wins.

Optional Feature:
- Macro: RED_SEQ_OPCNT_EN.
- With it:
  - Extra output op_count [15:0] counts completed out handshakes.
  - Saturates at 16'hFFFF.
  - Clears on rst.
- Without it: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package red_seq_pkg:
  - State enum/localparams (IDLE, ADD, DONE).
  - ACC_W default.
  - Addend-order constants (OP_C=0, OP_B=1, OP_D=2).
- Sub-module: reuse the existing cla_4bit as the single nibble adder. Its G output is the carry into the next nibble; P is unused.
- All other logic (FSM, counters, operand mux, accumulator) is in red_seq_ctrl.

Test Plan:
- Basic: A=16'h0102, B=16'h0304, out_ready=1 → out_valid 9 cycles after accept, Sum=16'h000A; busy high exactly 9 cycles.
- Negative extreme: A=16'h8080, B=16'h8080 → Sum=16'hFE00 (-512). Positive extreme: A=B=16'h7F7F → Sum=16'h01FC.
- Mixed signs: A=16'hFF01, B=16'h0280 → Sum=16'hFF82 (-126). Toggle A/B randomly during ADD → result unchanged.
- Backpressure: out_ready=0 for 20 cycles after out_valid → Sum is stable and in_ready=0 throughout. Then out_ready=1 → one handshake, IDLE next cycle.
- Reset mid-op: assert rst at ADD cycle 4 → next edge out_valid=0, in_ready=1, Sum=0. A new op A=16'h0101, B=16'h0101 → Sum=16'h0004.
- Back-to-back, with RED_SEQ_OPCNT_EN: 5 ops with in_valid and out_ready held high → accepts spaced 11 cycles apart, op_count=5.
